pdm_cic_decimator: RTL and testbench

Converts the 1-bit PDM stream from the microphone edge sampler into signed PCM samples. It uses a STAGES-order CIC (cascaded integrator-comb) decimator with power-of-two decimation DECIM. The block sits directly downstream of the edge sampler: it consumes that stage's `sample_en` / `sampled_bit` pair and produces one `pcm_valid`-qualified sample every DECIM input bits.

---
 rtl/pdm_cic_decimator.sv | 116 +++++++++++
 tb/tb_pdm_cic_decimator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
// CIC decimator: turns the strobed 1-bit PDM stream into signed, saturated PCM samples.
// Integrators run at the strobe rate; a one-stage-per-cycle comb pipeline runs once per tick.
module pdm_cic_decimator #(
  parameter int STAGES = 4,
  parameter int DECIM  = 64,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic                    sampled_bit,
  output logic signed [OUT_W-1:0] pcm_sample,
  output logic                    pcm_valid
);

  localparam int L     = $clog2(DECIM);
  localparam int G     = STAGES * L;
  localparam int ACC_W = G + 2;
  localparam int SHIFT = G - (OUT_W - 1);
  localparam int TW    = $clog2(STAGES + 1);

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam acc_t SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  acc_t             r_integ [STAGES];
  acc_t             r_y     [STAGES];  // r_y[0] is the comb input capture
  acc_t             r_d     [STAGES];
  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_flag;
  logic [L-1:0]     r_dec_cnt;
  logic [TW-1:0]    r_tick_cnt;

  acc_t             w_x;
  acc_t             w_integ_nxt [STAGES];
  acc_t             w_diff      [STAGES];
  acc_t             w_shifted;
  logic [OUT_W-1:0] w_sat;
  logic             w_tick;

  always_comb begin
    w_x            = sampled_bit ? acc_t'(1) : '1;
    w_integ_nxt[0] = r_integ[0] + w_x;
    for (int k = 1; k < STAGES; k++) begin
      w_integ_nxt[k] = r_integ[k] + r_integ[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_diff[k] = r_y[k] - r_d[k];
    end
    w_tick    = sample_en && (&r_dec_cnt);
    w_shifted = w_diff[STAGES-1] >>> SHIFT;
    w_sat     = w_shifted[OUT_W-1:0];
    if (w_shifted > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_shifted < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end
  end

  // NOTE: every register here, arrays included, is state the spec clears on reset,
  // so the arrays are reset in loops rather than left as uninitialised storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_integ[k] <= '0;
        r_y[k]     <= '0;
        r_d[k]     <= '0;
      end
      r_v        <= '0;
      r_flag     <= '0;
      r_dec_cnt  <= '0;
      r_tick_cnt <= '0;
      pcm_sample <= '0;
      pcm_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give the registered cascade: each integrator
      // sees the previous stage's value from before this edge.
      if (sample_en) begin
        for (int k = 0; k < STAGES; k++) begin
          r_integ[k] <= w_integ_nxt[k];
        end
        r_dec_cnt <= r_dec_cnt + 1'b1;
      end

      r_v[0]    <= w_tick;
      r_flag[0] <= (r_tick_cnt == TW'(STAGES));
      if (w_tick) begin
        r_y[0] <= w_integ_nxt[STAGES-1];
        if (r_tick_cnt != TW'(STAGES)) begin
          r_tick_cnt <= r_tick_cnt + 1'b1;
        end
      end

      // Comb stage k fires in the cycle its valid bit is set.
      for (int k = 0; k < STAGES; k++) begin
        if (r_v[k]) begin
          r_d[k] <= r_y[k];
        end
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        r_v[k+1]    <= r_v[k];
        r_flag[k+1] <= r_flag[k];
        if (r_v[k]) begin
          r_y[k+1] <= w_diff[k];
        end
      end

      pcm_valid <= r_v[STAGES-1] && r_flag[STAGES-1];
      if (r_v[STAGES-1]) begin
        pcm_sample <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: convolution-based CIC reference, per-cycle output compare,
// plus literal expectations for the canonical PDM patterns.
module tb_pdm_cic_decimator;

  localparam int S     = 4;
  localparam int D     = 64;
  localparam int OW    = 16;
  localparam int G     = S * 6;
  localparam int SHIFT = G - (OW - 1);
  localparam int HL    = S * (D - 1) + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sample_en = 1'b0;
  logic                 sampled_bit = 1'b0;
  logic signed [OW-1:0] pcm_sample;
  logic                 pcm_valid;

  pdm_cic_decimator #(.STAGES(S), .DECIM(D), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .sampled_bit(sampled_bit),
    .pcm_sample(pcm_sample), .pcm_valid(pcm_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle", name, act, exp);
    end
  endtask

  typedef struct {
    longint due;
    int     val;
    bit     flag;
  } exp_t;

  int     h [HL];
  int     xq [$];
  exp_t   eq [$];
  longint cyc = 0;
  bit     armed = 0;
  int     tick_n = 0;
  int     exp_sample = 0;
  longint first_tick_cyc = -1;
  longint first_vcyc = -1;
  int     vcnt = 0;
  int     last_val = 0;

  // Impulse response of S cascaded length-D boxcars.
  task automatic build_h();
    int tmp [HL];
    int len;
    foreach (h[i]) h[i] = 0;
    h[0] = 1;
    len  = 1;
    repeat (S) begin
      foreach (tmp[i]) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < D; j++) tmp[i+j] += h[i];
      len += D - 1;
      h = tmp;
    end
  endtask

  // Reference: each tick's output is the convolution of the input history with h,
  // delayed S-1 strobes by the registered integrator cascade, then scaled and clipped.
  always @(posedge clk) begin
    int y, r, n, idx;
    cyc++;
    if (rst) begin
      armed = 1;
      xq.delete();
      eq.delete();
      tick_n = 0;
      exp_sample = 0;
    end else if (armed && sample_en) begin
      xq.push_back(sampled_bit ? 1 : -1);
      if (xq.size() % D == 0) begin
        tick_n++;
        n = xq.size() - 1;
        y = 0;
        for (int j = 0; j < HL; j++) begin
          idx = n - (S - 1) - j;
          if (idx >= 0) y += h[j] * xq[idx];
        end
        r = y >>> SHIFT;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        eq.push_back('{due: cyc + S, val: r, flag: (tick_n > S)});
        if (tick_n == S + 1) first_tick_cyc = cyc - 1;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    if (armed) begin
      exp_v = 0;
      if (eq.size() > 0 && eq[0].due == cyc) begin
        exp_sample = eq[0].val;
        exp_v      = eq[0].flag;
        void'(eq.pop_front());
      end
      check("pcm_valid", {63'd0, pcm_valid}, {63'd0, exp_v});
      check("pcm_sample", pcm_sample, exp_sample);
      if (pcm_valid) begin
        if (vcnt == 0) first_vcyc = cyc;
        vcnt++;
        last_val = pcm_sample;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input int gap);
    sample_en   = 1'b1;
    sampled_bit = b;
    step();
    sample_en = 1'b0;
    repeat (gap) begin
      sampled_bit = 1'($urandom);
      step();
    end
  endtask

  task automatic do_reset(input logic with_en);
    rst         = 1'b1;
    sample_en   = with_en;
    sampled_bit = 1'b1;
    step();
    rst       = 1'b0;
    sample_en = 1'b0;
    check("reset pcm_valid", {63'd0, pcm_valid}, 0);
    check("reset pcm_sample", pcm_sample, 0);
    vcnt = 0;
    first_vcyc = -1;
    first_tick_cyc = -1;
  endtask

  task automatic drain();
    repeat (12) step();
  endtask

  initial begin
    build_h();
    step();
    step();
    do_reset(1'b0);

    for (int i = 0; i < 8 * D; i++) send(1'b1, 1);
    drain();
    check("ones count", vcnt, 4);
    check("ones value", last_val, 32767);
    check("ones latency", first_vcyc - first_tick_cyc, 5);

    do_reset(1'b1);
    for (int i = 0; i < 8 * D; i++) send(1'b0, 1);
    drain();
    check("zeros count", vcnt, 4);
    check("zeros value", last_val, -32768);

    do_reset(1'b0);
    for (int i = 0; i < 8 * D; i++) send(1'(i % 2 == 0), 1);
    drain();
    check("alt value", last_val, 0);

    do_reset(1'b0);
    for (int i = 0; i < 10 * D; i++) send(1'(i % 4 != 3), 1);
    drain();
    check("75pct count", vcnt, 6);
    check("75pct value", last_val, 16384);

    // Reset two cycles after a flagged tick discards that tick's sample.
    do_reset(1'b0);
    for (int i = 0; i < 7 * D; i++) send(1'($urandom), 1);
    do_reset(1'b1);
    for (int i = 0; i < 5 * D - 1; i++) send(1'($urandom), 1);
    drain();
    check("midreset early", vcnt, 0);
    send(1'($urandom), 1);
    drain();
    check("midreset count", vcnt, 1);

    do_reset(1'b0);
    for (int i = 0; i < 12 * D; i++) send(1'($urandom), $urandom_range(2, 40));
    drain();
    check("irregular count", vcnt, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
